// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider and its operand issuer:
// default operand width, divide-by-zero quotient and the issuer state encoding.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    // Quotient reported for a zero divisor at the default width.
    localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUOT = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SEND_A = 3'd2,
        SEND_B = 3'd3,
        WAIT   = 3'd4,
        CLEAR  = 3'd5,
        DBZ    = 3'd6
    } issuer_state_e;

endpackage

// File: rtl/div_job_fifo.sv
// Synchronous job FIFO. Pointers carry an extra wrap bit so full and empty
// are told apart without a separate counter; a push while full is dropped.
module div_job_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    a_no_pop_when_empty: assert property (
        @(posedge clock) disable iff (reset) pop_i |-> !empty_o
    );

endmodule

// File: rtl/div_operand_issuer.sv
// Front end of the repeated-subtraction divider: queues (dividend, divisor) jobs and
// sequences each into the divider; zero divisors are answered locally.
module div_operand_issuer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_dbz,
    output logic             div_start,
    output logic [WIDTH-1:0] div_data,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quot,
    input  logic [WIDTH-1:0] div_rem,
    output logic             div_clear,
    output logic             busy
);

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [2*WIDTH-1:0] fifo_head;
    logic [WIDTH-1:0]   head_dividend, head_divisor;

    issuer_state_e      state_q, state_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               valid_q, valid_d;
    logic               result_free;

    div_job_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_job_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (in_valid),
        .push_data_i ({in_dividend, in_divisor}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign {head_dividend, head_divisor} = fifo_head;

    // A job is only started once the result register is free or being drained this
    // cycle, so a later load can never overwrite an unconsumed result.
    assign result_free = !valid_q || out_ready;

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        valid_d    = valid_q && !out_ready;
        fifo_pop   = 1'b0;
        div_start  = 1'b0;
        div_data   = '0;
        div_clear  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && result_free) begin
                    fifo_pop   = 1'b1;
                    dividend_d = head_dividend;
                    divisor_d  = head_divisor;
                    state_d    = (head_divisor == '0) ? DBZ : START;
                end
            end
            START: begin
                div_start = 1'b1;
                state_d   = SEND_A;
            end
            SEND_A: begin
                div_data = dividend_q;
                state_d  = SEND_B;
            end
            SEND_B: begin
                div_data = divisor_q;
                state_d  = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    quot_d  = div_quot;
                    rem_d   = div_rem;
                    dbz_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                div_clear = 1'b1;
                state_d   = IDLE;
            end
            DBZ: begin
                quot_d  = '1;
                rem_d   = dividend_q;
                dbz_d   = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            valid_q    <= valid_d;
        end
    end

    assign in_ready  = !fifo_full;
    assign out_valid = valid_q;
    assign out_quot  = quot_q;
    assign out_rem   = rem_q;
    assign out_dbz   = dbz_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

    a_start_clear_exclusive: assert property (
        @(posedge clock) disable iff (reset) !(div_start && div_clear)
    );

    a_result_held: assert property (
        @(posedge clock) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable({out_quot, out_rem, out_dbz}))
    );

endmodule

// File: tb/tb_div_operand_issuer.sv
// Scoreboard bench for div_operand_issuer: jobs are predicted with plain division on
// acceptance and compared in order on delivery; a behavioural divider answers the far side.
module tb_div_operand_issuer;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_quot;
    logic [W-1:0] out_rem;
    logic         out_dbz;
    logic         div_start;
    logic [W-1:0] div_data;
    logic         div_done;
    logic [W-1:0] div_quot = '0;
    logic [W-1:0] div_rem = '0;
    logic         div_clear;
    logic         busy;

    logic         m_done = 1'b0;
    logic         late_done;
    assign div_done = m_done | late_done;

    always #5 clock = ~clock;

    div_operand_issuer #(
        .WIDTH (W),
        .DEPTH (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .out_dbz     (out_dbz),
        .div_start   (div_start),
        .div_data    (div_data),
        .div_done    (div_done),
        .div_quot    (div_quot),
        .div_rem     (div_rem),
        .div_clear   (div_clear),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {quotient, remainder, dbz} straight from the arithmetic definition.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return {16'hFFFF, a, 1'b1};
        return {W'(a / b), W'(a % b), 1'b0};
    endfunction

    // ---------------- scoreboard: predict on accept, compare on delivery ----------------
    logic [2*W:0] exp_q[$];
    int           n_nz = 0;
    logic         hold_prev = 1'b0;
    logic [2*W:0] hold_val;

    always begin
        @(negedge clock);
        #4;
        if (reset) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_div(in_dividend, in_divisor));
                if (in_divisor != 0) n_nz++;
            end
            if (hold_prev)
                check("result_stable_while_stalled", {out_valid, out_quot, out_rem, out_dbz}, {1'b1, hold_val});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result_valid", out_valid, 1'b0);
                else                   check("result", {out_quot, out_rem, out_dbz}, exp_q.pop_front());
            end
            hold_prev = out_valid && !out_ready;
            hold_val  = {out_quot, out_rem, out_dbz};
        end
    end

    // ---------------- consumer ready: 0 never, 1 always, 2 random ----------------
    int rdy_mode = 0;
    always begin
        @(negedge clock);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- behavioural divider ----------------
    int           phase = 0;
    int           cnt = 0;
    int           lat_max = 3;
    bit           hold_done = 1'b0;
    bit           just_done = 1'b0;
    int           n_start = 0;
    int           n_clear = 0;
    logic [W-1:0] m_a, m_b;

    always begin
        @(negedge clock);
        if (reset) begin
            phase     = 0;
            m_done    = 1'b0;
            just_done = 1'b0;
        end else begin
            if (div_start) begin
                check("start_while_divider_idle", phase, 0);
                n_start++;
            end
            case (phase)
                0: begin
                    check("div_data_zero_idle", div_data, 0);
                    if (div_clear) check("spurious_div_clear", div_clear, 1'b0);
                    if (div_start) phase = 1;
                end
                1: begin
                    m_a   = div_data;
                    phase = 2;
                end
                2: begin
                    m_b   = div_data;
                    cnt   = $urandom_range(0, lat_max);
                    phase = 3;
                end
                3: begin
                    check("div_data_zero_wait", div_data, 0);
                    if (!hold_done) begin
                        if (cnt == 0) begin
                            check("divisor_nonzero_at_divider", (m_b != 0), 1'b1);
                            div_quot  = (m_b == 0) ? '1 : W'(m_a / m_b);
                            div_rem   = (m_b == 0) ? m_a : W'(m_a % m_b);
                            m_done    = 1'b1;
                            just_done = 1'b1;
                            phase     = 4;
                        end else begin
                            cnt--;
                        end
                    end
                end
                default: begin
                    if (just_done) begin
                        check("done_to_clear_and_valid", {div_clear, out_valid}, 2'b11);
                        just_done = 1'b0;
                    end
                    if (div_clear) begin
                        m_done = 1'b0;
                        n_clear++;
                        phase = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic send_job(input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        waited      = 0;
        while (!in_ready && waited < 500) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 500) check("accept_timeout_in_ready", in_ready, 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 2000) check("drain_timeout_pending", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_quot"},  out_quot, 0);
        check({tag, "_out_rem"},   out_rem, 0);
        check({tag, "_out_dbz"},   out_dbz, 1'b0);
        check({tag, "_div_start"}, div_start, 1'b0);
        check({tag, "_div_data"},  div_data, 0);
        check({tag, "_div_clear"}, div_clear, 1'b0);
        check({tag, "_busy"},      busy, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    logic [W-1:0] ra, rb;
    int           k, w, s0, c0;

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        late_done   = 1'b0;
        #1;
        check_reset_values("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // (100, 7): start two cycles after accept, operands on consecutive cycles, q=14 r=2
        rdy_mode    = 1;
        s0          = n_start;
        c0          = n_clear;
        in_valid    = 1'b1;
        in_dividend = 16'd100;
        in_divisor  = 16'd7;
        k = 0;
        while (!div_start && k < 10) begin
            @(negedge clock);
            k++;
            in_valid = 1'b0;
        end
        check("accept_to_start_cycles", k, 2);
        @(negedge clock);
        check("send_a_dividend", div_data, 16'd100);
        @(negedge clock);
        check("send_b_divisor", div_data, 16'd7);
        wait_drain();
        check("single_job_starts", n_start - s0, 1);
        check("single_job_clears", n_clear - c0, 1);

        // (5, 0): answered locally two edges after the pop, divider untouched
        s0          = n_start;
        in_valid    = 1'b1;
        in_dividend = 16'd5;
        in_divisor  = 16'd0;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clock);
            k++;
            in_valid = 1'b0;
        end
        check("dbz_accept_to_valid_cycles", k, 3);
        check("dbz_flag", out_dbz, 1'b1);
        wait_drain();
        check("dbz_no_div_start", n_start - s0, 0);

        // Stalled consumer: five jobs fit (one in flight + four queued), then in_ready drops
        rdy_mode = 0;
        @(negedge clock);
        s0 = n_start;
        send_job(16'd10, 16'd3, w); check("fill_job1_no_wait", w, 0);
        send_job(16'd20, 16'd3, w); check("fill_job2_no_wait", w, 0);
        send_job(16'd30, 16'd4, w); check("fill_job3_no_wait", w, 0);
        send_job(16'd40, 16'd5, w); check("fill_job4_no_wait", w, 0);
        send_job(16'd50, 16'd6, w); check("fill_job5_no_wait", w, 0);
        check("full_in_ready_low", in_ready, 1'b0);
        repeat (20) @(negedge clock);
        check("stalled_single_start", n_start - s0, 1);
        check("stalled_result_held", out_valid, 1'b1);
        check("stalled_still_full", in_ready, 1'b0);
        // A push offered in the very cycle of the first pop must still be refused.
        in_valid    = 1'b1;
        in_dividend = 16'd7;
        in_divisor  = 16'd7;
        check("push_refused_during_pop", in_ready, 1'b0);
        rdy_mode = 1;
        send_job(16'd7, 16'd7, w);
        check("push_accepted_after_pop", w, 1);
        wait_drain();

        // Back-to-back jobs with a free consumer come out in order
        send_job(16'd3, 16'd9, w);
        send_job(16'd200, 16'd10, w);
        wait_drain();

        // Randomised traffic
        rdy_mode = 2;
        lat_max  = 6;
        for (int j = 0; j < 150; j++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 3));
                default: rb = W'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clock);
            send_job(ra, rb, w);
        end
        wait_drain();
        check("total_starts_vs_nonzero_jobs", n_start, n_nz);
        check("total_clears_vs_nonzero_jobs", n_clear, n_nz);

        // Reset while the divider is in WAIT with two jobs queued
        rdy_mode  = 1;
        hold_done = 1'b1;
        send_job(16'd50, 16'd3, w);
        send_job(16'd60, 16'd4, w);
        send_job(16'd70, 16'd5, w);
        k = 0;
        while (phase != 3 && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("reached_wait_before_reset", phase, 3);
        #1 reset = 1'b1;
        #1;
        check_reset_values("midrun_reset");
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b0;
        hold_done = 1'b0;
        @(negedge clock);
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_in_ready", in_ready, 1'b1);
        late_done = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check("late_done_ignored", {out_valid, busy, div_start, div_clear}, 4'b0000);
        end
        late_done = 1'b0;
        @(negedge clock);
        send_job(16'd1000, 16'd33, w);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_operand_issuer.md
# div_operand_issuer

Front end of the repeated-subtraction divider. Buffers (dividend, divisor) jobs in a small FIFO and sequences each job into the divider controller/datapath: `start`, then the dividend on the shared data bus, then the divisor. It waits for `done`, captures quotient and remainder into a single result register with a valid/ready output, then pulses the divider back to idle. Divide-by-zero jobs are resolved locally and never reach the divider, which would never terminate on them.

## Interface
- `WIDTH`, 16: operand, quotient and remainder width.
- `DEPTH`, 4: job FIFO entries; power of two, ≥2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: job offered.
- `in_ready` out 1: `!fifo_full`. A job is accepted when `in_valid && in_ready` at a clock edge.
- `in_dividend` in WIDTH: dividend of offered job.
- `in_divisor` in WIDTH: divisor of offered job.
- `out_valid` out 1: result register holds an unconsumed result.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `out_quot` out WIDTH: quotient.
- `out_rem` out WIDTH: remainder.
- `out_dbz` out 1: result came from a divisor of 0.
- `div_start` out 1: divider `start`; one-cycle pulse.
- `div_data` out WIDTH: divider data-in bus (feeds its A and B load).
- `div_done` in 1: divider `done`; level, held until cleared.
- `div_quot` in WIDTH: divider P counter value.
- `div_rem` in WIDTH: divider X-out register value.
- `div_clear` out 1: one-cycle synchronous return-to-S0 for the divider.
- `busy` out 1: FSM not in IDLE, or FIFO non-empty.

## Operation
- FIFO: DEPTH × 2·WIDTH, first-in first-out. Read/write pointers carry one extra wrap bit; full = same index with opposite wrap bit.
  - Push when full is blocked: `in_ready` is low, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
- FSM states and transitions:
  - IDLE → pop: when the FIFO is non-empty and `!out_valid || out_ready`, pop the head into the job registers. Go to DBZ if divisor == 0, else START.
  - START: `div_start`=1 → SEND_A.
  - SEND_A: `div_data`=dividend → SEND_B.
  - SEND_B: `div_data`=divisor → WAIT.
  - WAIT: on `div_done`=1, capture `div_quot`/`div_rem` into `out_quot`/`out_rem`, set `out_dbz`=0, set `out_valid`=1 → CLEAR. Otherwise stay in WAIT.
  - CLEAR: `div_clear`=1 → IDLE.
  - DBZ: `out_quot` = all ones, `out_rem` = dividend, `out_dbz`=1, `out_valid`=1 → IDLE.
- Result register: `out_valid` clears on an accept unless a load occurs in the same cycle; a load wins.
- `div_data` is 0 outside SEND_A and SEND_B.
- Reset mid-operation: the FIFO is flushed, the FSM returns to IDLE and any in-flight result is discarded. The system applies the same reset to the divider, so no `div_clear` is issued on reset.
- `div_done` seen outside WAIT is ignored.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_quot`=0, `out_rem`=0, `out_dbz`=0, `div_start`=0, `div_data`=0, `div_clear`=0, `busy`=0.
- Divider interface alignment. If `div_start` is high in cycle k:
  - the divider samples it in S0 and enters S1;
  - the dividend is on `div_data` in cycle k+1 (divider S1, LdA);
  - the divisor is on `div_data` in cycle k+2 (divider S2, LdB).
- Accept to `div_start`: 2 cycles minimum when the FIFO is empty and idle (write edge, then IDLE pop edge, then START).
- `div_done` to `out_valid`: registered; `out_valid` is high the cycle after `div_done` is first sampled high. `div_clear` is high in that same cycle.
- Next `div_start` no earlier than 2 cycles after `div_clear`.
- DBZ job: pop edge → `out_valid` after 2 edges; zero divider activity.
- `out_valid`, `out_quot`, `out_rem` and `out_dbz` are stable while `out_valid && !out_ready`.

## Structure
- Shared package `div_pkg`:
  - FSM state localparams: IDLE, START, SEND_A, SEND_B, WAIT, CLEAR, DBZ; 3-bit encoding.
  - Default WIDTH.
  - DBZ quotient constant (all ones).
  - The divider controller imports the same package for its start/done contract.
- One sub-module, `div_job_fifo`: parameterised synchronous FIFO with async reset, push/pop/full/empty.
- The FSM and result register live in `div_operand_issuer`.

## Test plan
- Push (100, 7); divider model returns q=14, r=2 → `div_data` 100 then 7 on consecutive cycles after `div_start`; `out_quot`=14, `out_rem`=2, `out_dbz`=0; one `div_clear` pulse.
- Push (5, 0) → no `div_start`; `out_quot`=0xFFFF, `out_rem`=5, `out_dbz`=1.
- Hold `out_ready`=0 and push 5 jobs → `in_ready` drops after the 4th job is in the FIFO. A 4th-and-5th push occurring in the same cycle as the first pop is still refused. No second `div_start` is issued until the first result is accepted.
- Push (3, 9), then (200, 10) back-to-back with `out_ready`=1 → results arrive in order: (0, 3) then (20, 0); `div_start` never occurs while the FSM is not IDLE.
- Assert `reset` during WAIT with 2 jobs queued → all outputs at their reset values immediately. After release the FIFO is empty, `busy`=0, and a late `div_done` is ignored.
